// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// Supports full-throughput back-pressure, flush bubbles and exception-entry bubbles.
module pipe_stage_skid #(
    parameter int unsigned DATA_W   = 96,
    parameter int unsigned EXC_W    = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic [1:0]        occupancy
);

    // Handshake: a transfer occurs on a rising edge where valid && ready are both
    // high; valid must not depend on ready, and ready here is a pure register output.

    localparam int unsigned BW = 32 + 32 + DATA_W + 1 + EXC_W;
    localparam logic [BW-1:0] RESET_BUBBLE = {RESET_PC, {(BW - 32){1'b0}}};
    localparam logic [BW-1:0] EXC_BUBBLE   = {EXC_PC, {(BW - 32){1'b0}}};

    logic [BW-1:0] main_q, main_d;
    logic [BW-1:0] skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [BW-1:0] in_bundle;
    logic          main_free;
    logic          in_xfer;

    assign in_bundle = {in_pc, in_instr, in_data, in_bd, in_exc};
    assign main_free = !out_valid_q || out_ready;
    assign in_xfer   = in_valid && !skid_valid_q;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (req) begin
            main_d       = EXC_BUBBLE;
            skid_d       = '0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (flush) begin
            main_d       = RESET_BUBBLE;
            skid_d       = '0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            // A full skid always drains first; in_ready is low so no input competes.
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d      = in_bundle;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = in_bundle;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q       <= RESET_BUBBLE;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign {out_pc, out_instr, out_data, out_bd, out_exc} = main_q;
    assign out_valid = out_valid_q;
    assign in_ready  = !skid_valid_q;
    assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake and a one-entry skid buffer. It is the successor to the fixed-width inter-stage latches (EX→MEM and friends). Besides passing the instruction bundle through, it supports back-pressure at full throughput, a flush that inserts a bubble, and an exception-entry request that loads the handler PC into the bubble. It sits between any two pipeline stages of the CPU; each stage boundary gets one instance.

## Interface
Parameters:
- DATA_W, 96, width of the opaque payload (e.g. A3/WD/RES/RD2 concatenated by the instantiating stage)
- EXC_W, 5, width of the exception-code field
- RESET_PC, 32'h0000_3000, PC carried by reset/flush bubbles
- EXC_PC, 32'h0000_4180, PC carried by the exception-entry bubble

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous reset, active-low (reset==0 resets on the next clk edge)
- req  in  1  exception entry: replace stage contents with a handler bubble
- flush  in  1  kill stage contents, insert a plain bubble
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_pc  in  32  instruction PC
- in_instr  in  32  instruction word
- in_data  in  DATA_W  payload
- in_bd  in  1  branch-delay-slot flag
- in_exc  in  EXC_W  exception code (0 = none)
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts
- out_pc, out_instr, out_data, out_bd, out_exc  out  32/32/DATA_W/1/EXC_W  registered bundle
- occupancy  out  2  entries held (0..2)

## Operation
- Storage consists of the main register (drives the out_* fields), the skid register, and the valid bits out_valid and skid_valid.
- Transfers:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- Priority per edge is reset > req > flush > normal.
- Reset (reset==0):
  - out_valid=0, skid_valid=0, out_pc=RESET_PC.
  - out_instr, out_data, out_bd and out_exc are all 0.
  - The skid fields clear.
  - Any input transfer in that cycle is discarded.
- req=1: same as reset, except out_pc=EXC_PC. The input transfer is discarded.
- flush=1 (req=0): identical to reset. The input transfer is discarded.
- Normal operation, with the main register considered free when !out_valid || out_ready:
  - skid_valid=1 and main free: skid moves to main and skid_valid→0. A simultaneous input transfer is impossible, because in_ready=0.
  - skid_valid=0, main free, input transfer: the input is loaded into main and out_valid=1.
  - skid_valid=0, main free, no input: out_valid→0 and the data fields hold their values.
  - main not free, input transfer: the input is loaded into skid and skid_valid=1.
  - main not free, no input: hold.
- Bundle fields never change while out_valid && !out_ready. This holds except under reset/req/flush.
- occupancy = out_valid + skid_valid.

## Timing
- Latency is 1 cycle from the input transfer to out_valid when the stage is empty or draining.
- Throughput is 1 bundle/cycle with out_ready held high. in_ready stays 1.
- in_ready is registered with no combinational path from out_ready. It drops the cycle after the skid fills and rises the cycle after the skid drains.
- After out_ready deasserts, at most one more bundle is accepted.
- req/flush act on the edge where they are sampled. The bubble is visible the next cycle with out_valid=0 and in_ready=1.
- Reset released (reset 0→1): the first input transfer can occur on the following edge.

## Test plan
- Reset, then streaming: hold reset=0 for 2 cycles; check out_pc=0x3000, out_valid=0, in_ready=1, occupancy=0. Release, then drive 4 bundles with PC 0x3000..0x300C on consecutive cycles with out_ready=1. Out shows the same PCs 1 cycle later, back-to-back.
- Back-pressure:
  - Stream PCs 0x3000, 0x3004, 0x3008 and drop out_ready after the first reaches the output.
  - 0x3004 goes to the skid, occupancy=2, in_ready=0, and 0x3008 is held upstream.
  - Raise out_ready; the outputs are 0x3004 then 0x3008 with no loss and no duplication.
- Exception entry:
  - With occupancy=2, pulse req=1 together with in_valid=1.
  - Next cycle: out_pc=0x4180, out_valid=0, out_exc=0, occupancy=0, in_ready=1.
  - The concurrent input is not output.
- Flush vs req priority:
  - flush=1 with req=0 gives out_pc=0x3000.
  - flush=1 with req=1 gives out_pc=0x4180.
  - Both cases discard the skid contents.
- Field passthrough: in_bd=1, in_exc=5'd12, in_data=all-ones pattern → out_bd=1, out_exc=12, out_data identical. The fields stay stable across 3 stalled cycles.
- Reset mid-stall: occupancy=2 with reset=0 → reset values appear next cycle and no stale bundle ever emerges.
